// File: rtl/perceptron_pkg.sv
// Shared types and defaults for the perceptron trainer and its dot-product unit.
// Optional statistics counters in the trainer are enabled by PERCEPTRON_TRAINER_STATS_EN.
package perceptron_pkg;

    localparam int unsigned WEIGHT_NUMBER = 62;
    localparam int unsigned WIDTH         = 8;
    localparam int unsigned INDEX         = 6;
    localparam int unsigned DEFAULT_DEPTH = 4;
    localparam int unsigned DEFAULT_THETA = (193 * (WEIGHT_NUMBER - 1)) / 100 + 14;
    localparam int unsigned SW            = WIDTH + $clog2(WEIGHT_NUMBER) + 1;

    typedef logic signed [WIDTH-1:0]      weight_t;
    typedef weight_t [WEIGHT_NUMBER-1:0]  weight_row_t;
    typedef logic signed [SW-1:0]         sum_t;
    typedef logic [WEIGHT_NUMBER-2:0]     hist_t;
    typedef logic [INDEX-1:0]             idx_t;

    typedef struct packed {
        idx_t        idx;
        hist_t       history;
        weight_row_t row;
        sum_t        y;
        logic        pred;
    } trainer_rec_t;

    localparam weight_t W_MAX = {1'b0, {(WIDTH-1){1'b1}}};
    localparam weight_t W_MIN = {1'b1, {(WIDTH-1){1'b0}}};

    // Step a weight by +1 (up=1) or -1 (up=0), clamping at the signed limits.
    function automatic weight_t sat_add(input weight_t w, input logic up);
        if (up) begin
            return (w == W_MAX) ? w : w + weight_t'(1);
        end
        return (w == W_MIN) ? w : w - weight_t'(1);
    endfunction

endpackage

// File: rtl/perceptron_dot.sv
// Combinational perceptron dot product: bias plus history-signed weights.
// History bit 1 contributes +w, bit 0 contributes -w.
module perceptron_dot
    import perceptron_pkg::*;
(
    input  weight_row_t weights_i,
    input  hist_t       history_i,
    output sum_t        y_o
);

    sum_t acc;

    always_comb begin
        acc = sum_t'(weight_t'(weights_i[0]));
        for (int unsigned i = 1; i < WEIGHT_NUMBER; i++) begin
            if (history_i[i-1]) begin
                acc = acc + sum_t'(weight_t'(weights_i[i]));
            end else begin
                acc = acc - sum_t'(weight_t'(weights_i[i]));
            end
        end
    end

    assign y_o = acc;

endmodule

// File: rtl/perceptron_trainer.sv
// Perceptron predictor write side: predicts, queues in-flight records, trains on resolve.
// Define PERCEPTRON_TRAINER_STATS_EN to add saturating prediction/mispredict/train counters.
module perceptron_trainer
    import perceptron_pkg::*;
#(
    parameter int unsigned DEPTH = DEFAULT_DEPTH,
    parameter int unsigned THETA = DEFAULT_THETA
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        pred_valid,
    output logic        pred_ready,
    input  idx_t        pred_idx,
    input  hist_t       pred_history,
    input  weight_row_t weights_in,
    output logic        pred_taken,
    input  logic        resolve_valid,
    input  logic        resolve_taken,
    input  logic        flush,
    output logic        update_enable,
    output idx_t        update_idx,
    output weight_row_t weight_update,
    output logic        resolve_mispredict,
    output logic        resolve_err
`ifdef PERCEPTRON_TRAINER_STATS_EN
    ,
    output logic [31:0] stat_predictions,
    output logic [31:0] stat_mispredicts,
    output logic [31:0] stat_trains
`endif
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    sum_t         pred_y;
    trainer_rec_t rec_q [DEPTH];
    trainer_rec_t head_rec;
    logic [PW-1:0] head_q, head_d, tail_q, tail_d;
    logic [CW-1:0] count_q, count_d;
    logic          push, pop, empty_resolve;
    logic          mispredict, train;
    sum_t          abs_y;
    weight_row_t   new_row;
    logic          upd_en_q, mis_q, err_q;
    idx_t          upd_idx_q, upd_idx_d;
    weight_row_t   upd_row_q, upd_row_d;

    perceptron_dot u_dot (
        .weights_i (weights_in),
        .history_i (pred_history),
        .y_o       (pred_y)
    );

    assign pred_taken    = ~pred_y[SW-1];
    assign pred_ready    = (count_q < CW'(DEPTH));
    assign push          = pred_valid && pred_ready && !flush;
    assign pop           = resolve_valid && (count_q != '0);
    assign empty_resolve = resolve_valid && (count_q == '0);
    assign head_rec      = rec_q[head_q];

    // t*x is +1 exactly when the outcome agrees with the history bit.
    always_comb begin
        mispredict = pop && (head_rec.pred != resolve_taken);
        abs_y      = head_rec.y[SW-1] ? -head_rec.y : head_rec.y;
        train      = pop && (mispredict || (abs_y <= sum_t'(THETA)));
        new_row[0] = sat_add(weight_t'(head_rec.row[0]), resolve_taken);
        for (int unsigned i = 1; i < WEIGHT_NUMBER; i++) begin
            new_row[i] = sat_add(weight_t'(head_rec.row[i]),
                                 resolve_taken == head_rec.history[i-1]);
        end
        upd_idx_d = upd_idx_q;
        upd_row_d = upd_row_q;
        if (train) begin
            upd_idx_d = head_rec.idx;
            upd_row_d = new_row;
        end
    end

    // Flush overrides pointer motion after the same-cycle pop has been trained.
    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (pop)  head_d = head_q + PW'(1);
        if (push) tail_d = tail_q + PW'(1);
        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
        if (flush) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            rec_q[tail_q] <= '{idx: pred_idx, history: pred_history, row: weights_in,
                               y: pred_y, pred: pred_taken};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_q    <= '0;
            tail_q    <= '0;
            count_q   <= '0;
            upd_en_q  <= 1'b0;
            mis_q     <= 1'b0;
            err_q     <= 1'b0;
            upd_idx_q <= '0;
            upd_row_q <= '0;
        end else begin
            head_q    <= head_d;
            tail_q    <= tail_d;
            count_q   <= count_d;
            upd_en_q  <= train;
            mis_q     <= mispredict;
            err_q     <= empty_resolve;
            upd_idx_q <= upd_idx_d;
            upd_row_q <= upd_row_d;
        end
    end

    assign update_enable      = upd_en_q;
    assign update_idx         = upd_idx_q;
    assign weight_update      = upd_row_q;
    assign resolve_mispredict = mis_q;
    assign resolve_err        = err_q;

`ifdef PERCEPTRON_TRAINER_STATS_EN
    logic [31:0] st_pred_q, st_mis_q, st_train_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st_pred_q  <= '0;
            st_mis_q   <= '0;
            st_train_q <= '0;
        end else begin
            if (push && (st_pred_q != '1))        st_pred_q  <= st_pred_q + 32'd1;
            if (mispredict && (st_mis_q != '1))   st_mis_q   <= st_mis_q + 32'd1;
            if (train && (st_train_q != '1))      st_train_q <= st_train_q + 32'd1;
        end
    end

    assign stat_predictions = st_pred_q;
    assign stat_mispredicts = st_mis_q;
    assign stat_trains      = st_train_q;
`endif

endmodule

// File: tb/tb_perceptron_trainer.sv
// Self-checking bench for perceptron_trainer: directed table, FIFO/flush/reset
// sequences, then randomized traffic against an arithmetic queue model.
module tb_perceptron_trainer;
    import perceptron_pkg::*;

    localparam int N    = WEIGHT_NUMBER;
    localparam int TH   = 131;
    localparam int NRND = 600;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        pred_valid, pred_ready, pred_taken;
    idx_t        pred_idx, update_idx;
    hist_t       pred_history;
    weight_row_t weights_in, weight_update;
    logic        resolve_valid, resolve_taken, flush;
    logic        update_enable, resolve_mispredict, resolve_err;
`ifdef PERCEPTRON_TRAINER_STATS_EN
    logic [31:0] stat_predictions, stat_mispredicts, stat_trains;
`endif

    perceptron_trainer dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .pred_valid         (pred_valid),
        .pred_ready         (pred_ready),
        .pred_idx           (pred_idx),
        .pred_history       (pred_history),
        .weights_in         (weights_in),
        .pred_taken         (pred_taken),
        .resolve_valid      (resolve_valid),
        .resolve_taken      (resolve_taken),
        .flush              (flush),
        .update_enable      (update_enable),
        .update_idx         (update_idx),
        .weight_update      (weight_update),
        .resolve_mispredict (resolve_mispredict),
        .resolve_err        (resolve_err)
`ifdef PERCEPTRON_TRAINER_STATS_EN
        ,
        .stat_predictions   (stat_predictions),
        .stat_mispredicts   (stat_mispredicts),
        .stat_trains        (stat_trains)
`endif
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int exp_w [N];

    // Stimulus log and model queue of log ids (oldest at front).
    int    wlog   [NRND][N];
    hist_t hlog   [NRND];
    int    idxlog [NRND];
    int    mq[$];
    bit    e_upd, e_mis, e_err;
    int    e_idx;

    typedef struct {
        int w0; int wi; bit h; bit t;
        bit e_pred; bit e_upd; bit e_mis; int e_w0; int e_wi;
    } vec_t;
    vec_t vt [9];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic chk_row(input string name);
        int bad = 0;
        int fi = 0;
        int fa = 0;
        for (int i = 0; i < N; i++) begin
            if (int'(weight_t'(weight_update[i])) != exp_w[i]) begin
                if (bad == 0) begin
                    fi = i;
                    fa = int'(weight_t'(weight_update[i]));
                end
                bad++;
            end
        end
        checks++;
        if (bad != 0) begin
            failures++;
            $display("FAIL %s: w[%0d] got %0d expected %0d (%0d weights wrong)",
                     name, fi, fa, exp_w[fi], bad);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_idle();
        pred_valid    = 1'b0;
        resolve_valid = 1'b0;
        resolve_taken = 1'b0;
        flush         = 1'b0;
    endtask

    task automatic fill_row(input int w0, input int wi);
        weights_in[0] = weight_t'(w0);
        for (int i = 1; i < N; i++) weights_in[i] = weight_t'(wi);
    endtask

    task automatic set_exp(input int w0, input int wi);
        exp_w[0] = w0;
        for (int i = 1; i < N; i++) exp_w[i] = wi;
    endtask

    task automatic chk_reset_state(input string tag);
        set_exp(0, 0);
        chk({tag, "_upd_en"}, int'(update_enable), 0);
        chk({tag, "_ready"}, int'(pred_ready), 1);
        chk({tag, "_mis"}, int'(resolve_mispredict), 0);
        chk({tag, "_err"}, int'(resolve_err), 0);
        chk({tag, "_idx"}, int'(update_idx), 0);
        chk_row({tag, "_row"});
    endtask

    function automatic int clamp(input int v);
        if (v > 127) return 127;
        if (v < -128) return -128;
        return v;
    endfunction

    function automatic int model_y(input int id);
        int y = wlog[id][0];
        for (int i = 1; i < N; i++) y += hlog[id][i-1] ? wlog[id][i] : -wlog[id][i];
        return y;
    endfunction

    function automatic void model_train(input int id, input bit t);
        int y  = model_y(id);
        int tv = t ? 1 : -1;
        int ay = (y < 0) ? -y : y;
        e_mis = ((y >= 0) != t);
        e_upd = e_mis || (ay <= TH);
        e_idx = idxlog[id];
        exp_w[0] = clamp(wlog[id][0] + tv);
        for (int i = 1; i < N; i++)
            exp_w[i] = clamp(wlog[id][i] + (hlog[id][i-1] ? tv : -tv));
    endfunction

    function automatic int rnd_weight(input int mode);
        int sel;
        if (mode == 0) return int'($urandom_range(0, 6)) - 3;
        sel = int'($urandom_range(0, 7));
        if (sel == 0) return 127;
        if (sel == 1) return -128;
        if (sel == 2) return int'($urandom_range(0, 255)) - 128;
        return int'($urandom_range(0, 2)) - 1;
    endfunction

    initial begin
        vt[0] = '{0,    0,    1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1,    1};
        vt[1] = '{127,  127,  1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 0,    0};
        vt[2] = '{127,  127,  1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 126,  126};
        vt[3] = '{-128, -128, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0,    0};
        vt[4] = '{-128, -128, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, -128, -127};
        vt[5] = '{1,    1,    1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 2,    0};
        vt[6] = '{2,    2,    1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1,    1};
        vt[7] = '{0,    0,    1'b0, 1'b0, 1'b1, 1'b1, 1'b1, -1,   1};
        vt[8] = '{127,  0,    1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 127,  1};

        set_idle();
        pred_idx     = '0;
        pred_history = '1;
        fill_row(0, 0);
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk_reset_state("reset");
        rst_n = 1'b1;

        // Directed table: one push, one resolve per entry.
        for (int k = 0; k < 9; k++) begin
            pred_idx     = idx_t'(k + 1);
            fill_row(vt[k].w0, vt[k].wi);
            pred_history = vt[k].h ? '1 : '0;
            pred_valid   = 1'b1;
            #1;
            chk($sformatf("tbl%0d_pred", k), int'(pred_taken), int'(vt[k].e_pred));
            step();
            pred_valid    = 1'b0;
            resolve_valid = 1'b1;
            resolve_taken = vt[k].t;
            step();
            resolve_valid = 1'b0;
            chk($sformatf("tbl%0d_upd_en", k), int'(update_enable), int'(vt[k].e_upd));
            chk($sformatf("tbl%0d_mis", k), int'(resolve_mispredict), int'(vt[k].e_mis));
            if (vt[k].e_upd) begin
                set_exp(vt[k].e_w0, vt[k].e_wi);
                chk($sformatf("tbl%0d_idx", k), int'(update_idx), k + 1);
                chk_row($sformatf("tbl%0d_row", k));
            end
        end

        // Fill to capacity (pointers start mid-ring, so the tail wraps).
        fill_row(0, 0);
        pred_history = '1;
        for (int k = 1; k <= 4; k++) begin
            pred_idx   = idx_t'(k);
            pred_valid = 1'b1;
            step();
        end
        chk("full_ready", int'(pred_ready), 0);
        pred_idx = idx_t'(9);
        step();
        pred_valid    = 1'b0;
        resolve_valid = 1'b1;
        resolve_taken = 1'b1;
        set_exp(1, 1);
        for (int k = 1; k <= 4; k++) begin
            step();
            chk($sformatf("fifo%0d_upd_en", k), int'(update_enable), 1);
            chk($sformatf("fifo%0d_idx", k), int'(update_idx), k);
        end
        step();
        resolve_valid = 1'b0;
        chk("fifo_drop_err", int'(resolve_err), 1);
        chk("fifo_drop_upd", int'(update_enable), 0);

        // Resolve and flush together: head trains, the rest is discarded.
        for (int k = 5; k <= 6; k++) begin
            pred_idx   = idx_t'(k);
            pred_valid = 1'b1;
            step();
        end
        pred_valid    = 1'b0;
        resolve_valid = 1'b1;
        resolve_taken = 1'b1;
        flush         = 1'b1;
        step();
        flush = 1'b0;
        chk("flush_upd_en", int'(update_enable), 1);
        chk("flush_idx", int'(update_idx), 5);
        chk("flush_ready", int'(pred_ready), 1);
        step();
        resolve_valid = 1'b0;
        chk("flush_err", int'(resolve_err), 1);
        chk("flush_no_upd", int'(update_enable), 0);

        // Reset asserted with three records queued and an update on the outputs.
        for (int k = 7; k <= 10; k++) begin
            pred_idx   = idx_t'(k);
            pred_valid = 1'b1;
            step();
        end
        pred_valid    = 1'b0;
        resolve_valid = 1'b1;
        step();
        resolve_valid = 1'b0;
        chk("prerst_upd_en", int'(update_enable), 1);
        rst_n = 1'b0;
        #1;
        chk_reset_state("midrst");
        #2;
        rst_n = 1'b1;
        resolve_valid = 1'b1;
        step();
        resolve_valid = 1'b0;
        chk("postrst_err", int'(resolve_err), 1);

        // Randomized traffic against the queue model.
        mq.delete();
        for (int c = 0; c < NRND; c++) begin
            int  mode;
            int  pre;
            bit  pv, rv, fl, tk;
            pv   = ($urandom_range(0, 99) < 60);
            rv   = ($urandom_range(0, 99) < 50);
            fl   = ($urandom_range(0, 99) < 4);
            tk   = $urandom_range(0, 1) == 1;
            mode = int'($urandom_range(0, 1));
            idxlog[c] = int'($urandom_range(0, 63));
            hlog[c]   = hist_t'({$urandom(), $urandom()});
            for (int i = 0; i < N; i++) wlog[c][i] = rnd_weight(mode);

            pred_valid    = pv;
            pred_idx      = idx_t'(idxlog[c]);
            pred_history  = hlog[c];
            for (int i = 0; i < N; i++) weights_in[i] = weight_t'(wlog[c][i]);
            resolve_valid = rv;
            resolve_taken = tk;
            flush         = fl;
            #1;
            chk($sformatf("rnd%0d_ready", c), int'(pred_ready), int'(mq.size() < 4));
            if (pv) chk($sformatf("rnd%0d_pred", c), int'(pred_taken), int'(model_y(c) >= 0));

            pre   = mq.size();
            e_err = rv && (pre == 0);
            e_upd = 1'b0;
            e_mis = 1'b0;
            if (rv && pre > 0) model_train(mq.pop_front(), tk);
            if (pv && pre < 4 && !fl) mq.push_back(c);
            if (fl) mq.delete();

            step();
            chk($sformatf("rnd%0d_err", c), int'(resolve_err), int'(e_err));
            chk($sformatf("rnd%0d_upd_en", c), int'(update_enable), int'(e_upd));
            chk($sformatf("rnd%0d_mis", c), int'(resolve_mispredict), int'(e_mis));
            if (e_upd) begin
                chk($sformatf("rnd%0d_idx", c), int'(update_idx), e_idx);
                chk_row($sformatf("rnd%0d_row", c));
            end
        end
        set_idle();
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
